// File: rtl/board_sprite_updater.sv
// board_sprite_updater
//   Multi-sprite board-RAM write engine (Pac-Man at index 0, ghosts at 1..N-1).
//   Accepts a batch of next block addresses. For each moved sprite, taken in index
//   order, it restores the tile under the old block, records the tile under the new
//   block, and then draws the sprite there. Each sprite keeps its own saved tile.
//   Optional feature macro: COLLISION_DETECT_EN. When it is defined, the engine
//   reports ghost/Pac-Man block sharing at the end of every batch. When it is not
//   defined, the collision output is tied to zero.
module board_sprite_updater #(
    parameter int NUM_SPRITES = 5,
    parameter int ADDR_W      = 10,
    parameter int TILE_W      = 4,
    parameter int EMPTY_TILE  = 0,
    parameter int PELLET_TILE = 1,
    parameter int RD_LATENCY  = 1
) (
    input  logic                          CLOCK_50,
    input  logic                          reset,
    input  logic                          move_valid,
    output logic                          move_ready,
    input  logic [NUM_SPRITES*ADDR_W-1:0] sprite_next,
    input  logic [NUM_SPRITES*TILE_W-1:0] sprite_tile,
    output logic [ADDR_W-1:0]             rd_addr,
    input  logic [TILE_W-1:0]             rd_data,
    output logic                          wren,
    output logic [ADDR_W-1:0]             wr_addr,
    output logic [TILE_W-1:0]             wr_data,
    output logic [NUM_SPRITES*ADDR_W-1:0] sprite_loc,
    output logic                          pellet_eaten,
    output logic                          done,
    output logic [NUM_SPRITES-1:0]        collision
);

    localparam int IDX_W = $clog2(NUM_SPRITES + 1);
    localparam int LAT_W = 2;
    localparam logic [TILE_W-1:0] EMPTY_C  = TILE_W'(EMPTY_TILE);
    localparam logic [TILE_W-1:0] PELLET_C = TILE_W'(PELLET_TILE);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_SPRITES);
    localparam logic [LAT_W-1:0]  LAT_END  = LAT_W'(RD_LATENCY - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_SCAN, ST_CLEAR, ST_READ, ST_CAPTURE, ST_DRAW, ST_COMMIT, ST_FINISH
    } state_t;

    state_t                   state_r;
    logic [IDX_W-1:0]         idx_r;
    logic [LAT_W-1:0]         lat_cnt_r;
    logic [ADDR_W-1:0]        next_r  [NUM_SPRITES];
    logic [TILE_W-1:0]        tile_r  [NUM_SPRITES];
    logic [ADDR_W-1:0]        loc_r   [NUM_SPRITES];
    logic [TILE_W-1:0]        under_r [NUM_SPRITES];
    logic [NUM_SPRITES-1:0]   placed_r;
    logic                     move_ready_r;
    logic [ADDR_W-1:0]        rd_addr_r;
    logic                     wren_r;
    logic [ADDR_W-1:0]        wr_addr_r;
    logic [TILE_W-1:0]        wr_data_r;
    logic                     pellet_r;
    logic                     done_r;

    logic [IDX_W-1:0]         sel_s;
    logic [ADDR_W-1:0]        cur_loc_s;
    logic [ADDR_W-1:0]        cur_next_s;
    logic                     clr_hit_s;
    logic [TILE_W-1:0]        clr_data_s;
    logic                     cap_hit_s;
    logic [TILE_W-1:0]        cap_under_s;

    // Clamp the sprite index so the final SCAN (idx == NUM_SPRITES) never indexes past the arrays
    always_comb begin
        if (idx_r < LAST_IDX) begin
            sel_s = idx_r;
        end else begin
            sel_s = {IDX_W{1'b0}};
        end
        cur_loc_s  = loc_r[sel_s];
        cur_next_s = next_r[sel_s];
    end

    // Lowest other placed sprite sharing the old block (restore tile) or the new block (inherit under)
    always_comb begin
        clr_hit_s   = 1'b0;
        clr_data_s  = under_r[sel_s];
        cap_hit_s   = 1'b0;
        cap_under_s = rd_data;
        for (int j = 0; j < NUM_SPRITES; j++) begin
            if (!clr_hit_s && placed_r[j] && (IDX_W'(j) != sel_s) && (loc_r[j] == cur_loc_s)) begin
                clr_hit_s  = 1'b1;
                clr_data_s = tile_r[j];
            end else begin
                clr_hit_s  = clr_hit_s;
            end
            if (!cap_hit_s && placed_r[j] && (IDX_W'(j) != sel_s) && (loc_r[j] == cur_next_s)) begin
                cap_hit_s   = 1'b1;
                cap_under_s = under_r[j];
            end else begin
                cap_hit_s   = cap_hit_s;
            end
        end
    end

    // Batch sequencer: scan sprites in index order, clear/read/capture/draw/commit each moved one
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            idx_r        <= {IDX_W{1'b0}};
            lat_cnt_r    <= {LAT_W{1'b0}};
            placed_r     <= {NUM_SPRITES{1'b0}};
            move_ready_r <= 1'b1;
            rd_addr_r    <= {ADDR_W{1'b0}};
            wren_r       <= 1'b0;
            wr_addr_r    <= {ADDR_W{1'b0}};
            wr_data_r    <= {TILE_W{1'b0}};
            pellet_r     <= 1'b0;
            done_r       <= 1'b0;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                next_r[i]  <= {ADDR_W{1'b0}};
                tile_r[i]  <= {TILE_W{1'b0}};
                loc_r[i]   <= {ADDR_W{1'b0}};
                under_r[i] <= EMPTY_C;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    wren_r   <= 1'b0;
                    pellet_r <= 1'b0;
                    done_r   <= 1'b0;
                    if (move_valid) begin
                        for (int i = 0; i < NUM_SPRITES; i++) begin
                            next_r[i] <= sprite_next[i*ADDR_W +: ADDR_W];
                            tile_r[i] <= sprite_tile[i*TILE_W +: TILE_W];
                        end
                        idx_r        <= {IDX_W{1'b0}};
                        move_ready_r <= 1'b0;
                        state_r      <= ST_SCAN;
                    end else begin
                        state_r      <= ST_IDLE;
                    end
                end
                ST_SCAN: begin
                    if (idx_r == LAST_IDX) begin
                        done_r  <= 1'b1;
                        state_r <= ST_FINISH;
                    end else if (placed_r[sel_s] && (cur_next_s == cur_loc_s)) begin
                        idx_r   <= idx_r + IDX_W'(1);
                        state_r <= ST_SCAN;
                    end else if (placed_r[sel_s]) begin
                        wren_r    <= 1'b1;
                        wr_addr_r <= cur_loc_s;
                        wr_data_r <= clr_data_s;
                        state_r   <= ST_CLEAR;
                    end else begin
                        rd_addr_r <= cur_next_s;
                        lat_cnt_r <= {LAT_W{1'b0}};
                        state_r   <= ST_READ;
                    end
                end
                ST_CLEAR: begin
                    wren_r    <= 1'b0;
                    rd_addr_r <= cur_next_s;
                    lat_cnt_r <= {LAT_W{1'b0}};
                    state_r   <= ST_READ;
                end
                ST_READ: begin
                    if (lat_cnt_r == LAT_END) begin
                        state_r   <= ST_CAPTURE;
                    end else begin
                        lat_cnt_r <= lat_cnt_r + LAT_W'(1);
                    end
                end
                ST_CAPTURE: begin
                    // Pac-Man always leaves an empty block behind, so a pellet is consumed
                    if (sel_s == {IDX_W{1'b0}}) begin
                        under_r[sel_s] <= EMPTY_C;
                        pellet_r       <= (cap_under_s == PELLET_C);
                    end else begin
                        under_r[sel_s] <= cap_under_s;
                        pellet_r       <= 1'b0;
                    end
                    wren_r    <= 1'b1;
                    wr_addr_r <= cur_next_s;
                    wr_data_r <= tile_r[sel_s];
                    state_r   <= ST_DRAW;
                end
                ST_DRAW: begin
                    wren_r   <= 1'b0;
                    pellet_r <= 1'b0;
                    state_r  <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    loc_r[sel_s]    <= cur_next_s;
                    placed_r[sel_s] <= 1'b1;
                    idx_r           <= idx_r + IDX_W'(1);
                    state_r         <= ST_SCAN;
                end
                ST_FINISH: begin
                    done_r       <= 1'b0;
                    move_ready_r <= 1'b1;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    wren_r       <= 1'b0;
                    pellet_r     <= 1'b0;
                    done_r       <= 1'b0;
                    move_ready_r <= 1'b1;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef COLLISION_DETECT_EN
    logic [NUM_SPRITES-1:0] collision_s;
    logic [NUM_SPRITES-1:0] collision_r;

    // Ghost i collides when both it and Pac-Man are placed on the same block
    always_comb begin
        collision_s = {NUM_SPRITES{1'b0}};
        for (int i = 1; i < NUM_SPRITES; i++) begin
            collision_s[i] = placed_r[0] & placed_r[i] & (loc_r[i] == loc_r[0]);
        end
    end

    // Sample collisions on the final scan so they appear together with done
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            collision_r <= {NUM_SPRITES{1'b0}};
        end else if ((state_r == ST_SCAN) && (idx_r == LAST_IDX)) begin
            collision_r <= collision_s;
        end else begin
            collision_r <= collision_r;
        end
    end

    assign collision = collision_r;
`else
    assign collision = {NUM_SPRITES{1'b0}};
`endif

    genvar g;
    generate
        for (g = 0; g < NUM_SPRITES; g++) begin : g_loc
            assign sprite_loc[g*ADDR_W +: ADDR_W] = loc_r[g];
        end
    endgenerate

    assign move_ready   = move_ready_r;
    assign rd_addr      = rd_addr_r;
    assign wren         = wren_r;
    assign wr_addr      = wr_addr_r;
    assign wr_data      = wr_data_r;
    assign pellet_eaten = pellet_r;
    assign done         = done_r;

endmodule

// File: tb/tb_board_sprite_updater.sv
// Directed testbench for board_sprite_updater with a 1-cycle-latency board RAM model.
module tb_board_sprite_updater;

    localparam int NS = 5;
    localparam int AW = 10;
    localparam int TW = 4;

    logic            CLOCK_50 = 1'b0;
    logic            reset;
    logic            move_valid;
    logic            move_ready;
    logic [NS*AW-1:0] sprite_next;
    logic [NS*TW-1:0] sprite_tile;
    logic [AW-1:0]   rd_addr;
    logic [TW-1:0]   rd_data;
    logic            wren;
    logic [AW-1:0]   wr_addr;
    logic [TW-1:0]   wr_data;
    logic [NS*AW-1:0] sprite_loc;
    logic            pellet_eaten;
    logic            done;
    logic [NS-1:0]   collision;

`ifdef COLLISION_DETECT_EN
    localparam logic [NS-1:0] COL_SHARED = 5'b00010;
`else
    localparam logic [NS-1:0] COL_SHARED = 5'b00000;
`endif

    board_sprite_updater dut (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .move_valid   (move_valid),
        .move_ready   (move_ready),
        .sprite_next  (sprite_next),
        .sprite_tile  (sprite_tile),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .wren         (wren),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .sprite_loc   (sprite_loc),
        .pellet_eaten (pellet_eaten),
        .done         (done),
        .collision    (collision)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Board RAM model: synchronous write, 1-cycle read, preloadable
    logic [TW-1:0] ram [0:1023];
    logic          ram_init;
    always @(posedge CLOCK_50) begin
        if (ram_init) begin
            for (int a = 0; a < 1024; a++) ram[a] <= 4'd0;
            ram[1]  <= 4'd4;
            ram[2]  <= 4'd7;
            ram[3]  <= 4'd6;
            ram[34] <= 4'd1;
        end else begin
            if (wren) ram[wr_addr] <= wr_data;
            rd_data <= ram[rd_addr];
        end
    end

    // Event log sampled on the falling edge
    logic [AW+TW-1:0] wr_q [$];
    int               pellet_cnt = 0;
    int               done_cnt   = 0;
    always @(negedge CLOCK_50) begin
        if (wren) wr_q.push_back({wr_addr, wr_data});
        if (pellet_eaten) pellet_cnt <= pellet_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    int               n_checks = 0;
    int               n_fail   = 0;
    logic [AW+TW-1:0] exp_q [$];
    int               wbase_g;
    int               pbase_g;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [NS*AW-1:0] pk(input int s0, input int s1, input int s2,
                                            input int s3, input int s4);
        return {10'(s4), 10'(s3), 10'(s2), 10'(s1), 10'(s0)};
    endfunction

    task automatic add_w(input int a, input int d);
        exp_q.push_back({10'(a), 4'(d)});
    endtask

    task automatic launch(input logic [NS*AW-1:0] nxt);
        wbase_g = wr_q.size();
        pbase_g = pellet_cnt;
        @(negedge CLOCK_50);
        sprite_next = nxt;
        move_valid  = 1'b1;
        @(posedge CLOCK_50);
        #1;
        move_valid  = 1'b0;
        sprite_next = ~nxt;
        check_value("busy_ready", move_ready, 1'b0);
    endtask

    task automatic run_batch(input string tag, input logic [NS*AW-1:0] nxt);
        int dbase;
        int cyc;
        dbase = done_cnt;
        launch(nxt);
        cyc = 0;
        while (done_cnt == dbase && cyc < 200) begin
            @(negedge CLOCK_50);
            cyc++;
        end
        check_value({tag, "_done"}, done_cnt - dbase, 1);
        @(negedge CLOCK_50);
        check_value({tag, "_n"}, wr_q.size() - wbase_g, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (wbase_g + i < wr_q.size()) check_value({tag, "_wr"}, wr_q[wbase_g + i], exp_q[i]);
        end
        exp_q.delete();
    endtask

    initial begin
        int cyc;
        logic found;
        reset       = 1'b1;
        ram_init    = 1'b1;
        move_valid  = 1'b0;
        sprite_next = '0;
        sprite_tile = {4'd13, 4'd12, 4'd11, 4'd10, 4'd9};
        repeat (3) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        ram_init = 1'b0;
        reset    = 1'b0;
        @(negedge CLOCK_50);
        check_value("rst_wren", wren, 1'b0);
        check_value("rst_done", done, 1'b0);
        check_value("rst_pellet", pellet_eaten, 1'b0);
        check_value("rst_col", collision, 5'd0);
        check_value("rst_loc", sprite_loc, 50'd0);
        check_value("rst_ready", move_ready, 1'b1);
        check_value("rst_addrs", {rd_addr, wr_addr, wr_data}, 24'd0);

        // 1: all unplaced, draws only
        add_w(33, 9); add_w(1, 10); add_w(2, 11); add_w(3, 12); add_w(4, 13);
        run_batch("b1", pk(33, 1, 2, 3, 4));
        check_value("b1_loc", sprite_loc, pk(33, 1, 2, 3, 4));
        check_value("b1_pellet", pellet_cnt - pbase_g, 0);
        check_value("b1_col", collision, 5'd0);
        check_value("b1_ready", move_ready, 1'b1);

        // 2: Pac-Man 33 -> 34 onto a pellet
        add_w(33, 0); add_w(34, 9);
        run_batch("b2", pk(34, 1, 2, 3, 4));
        check_value("b2_pellet", pellet_cnt - pbase_g, 1);

        // 4a: ghost2 onto ghost3's block inherits ghost3's saved tile
        add_w(2, 7); add_w(3, 11);
        run_batch("b3", pk(34, 1, 3, 3, 4));

        // 3/4b: ghost1 1 -> 2 reads 7; ghost2 leaving block 3 restores ghost3's tile
        add_w(1, 4); add_w(2, 10); add_w(3, 12); add_w(5, 11);
        run_batch("b4", pk(34, 2, 5, 3, 4));

        // 3/5: ghost1 leaves block 2 (restores 7) and lands on Pac-Man
        add_w(2, 7); add_w(34, 10);
        run_batch("b5", pk(34, 34, 5, 3, 4));
        check_value("b5_col", collision, COL_SHARED);
        check_value("b5_loc", sprite_loc, pk(34, 34, 5, 3, 4));

        // 2b: Pac-Man returns to 33 (now empty), ghost1's tile restored on 34
        add_w(34, 10); add_w(33, 9);
        run_batch("b6", pk(33, 34, 5, 3, 4));
        check_value("b6_pellet", pellet_cnt - pbase_g, 0);
        check_value("b6_col", collision, 5'd0);

        // 6: reset during READ of sprite 2
        launch(pk(33, 34, 6, 3, 4));
        found = 1'b0;
        cyc   = 0;
        while (!found && cyc < 100) begin
            @(negedge CLOCK_50);
            if (wren && wr_addr == 10'd5) found = 1'b1;
            cyc++;
        end
        check_value("b7_clear_seen", {found, wr_data}, {1'b1, 4'd0});
        @(posedge CLOCK_50);
        #1;
        reset = 1'b1;
        #1;
        check_value("b7_rst_wren", wren, 1'b0);
        repeat (2) @(negedge CLOCK_50);
        reset = 1'b0;
        @(negedge CLOCK_50);
        check_value("b7_ready", move_ready, 1'b1);
        check_value("b7_loc", sprite_loc, 50'd0);
        check_value("b7_col", collision, 5'd0);

        // After the aborted batch nothing is placed: draws only
        add_w(10, 9); add_w(11, 10); add_w(12, 11); add_w(13, 12); add_w(14, 13);
        run_batch("b8", pk(10, 11, 12, 13, 14));
        check_value("b8_loc", sprite_loc, pk(10, 11, 12, 13, 14));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
